game_supervisor: RTL and testbench
==================================

# game_supervisor

Game-flow controller for the racing game, sitting at the opposite end of the car-position interface from the player car controller. It consumes the car's registered position, spawns and scrolls one obstacle down a 4-lane track, and detects car/obstacle overlap. It keeps score and drives the `reset_game` input of the car controller. It also feeds obstacle position, score and `game_over` to the VGA renderer.

## Interface
- `TICK_DIV`, 833_334: clocks per motion tick (30 Hz at 25 MHz).
- `TRACK_LEFT`, 120: left track edge, px.
- `LANE_W`, 100: lane pitch, px.
- `OBS_OFS`, 25: obstacle x offset inside a lane.
- `OBS_W`, 50 / `OBS_H`, 60: obstacle size, px.
- `CAR_W`, 50 / `CAR_H`, 80: car size, px.
- `OBS_SPEED`, 4: base obstacle speed, px per tick.
- `CRASH_TICKS`, 60: ticks held in CRASH.
- `iVGA_CLK` in 1: clock.
- `iRST_n` in 1: reset, asynchronous, active-low.
- `Key2` in 1: start button, active-low, asynchronous to the clock.
- `car_h_pos` in 10: car left x.
- `car_v_pos` in 9: car top y.
- `reset_game` out 1: holds the car controller centred; high in WAIT.
- `obs_h_pos` out 10: obstacle left x.
- `obs_v_pos` out 9: obstacle top y.
- `obs_valid` out 1: obstacle drawn.
- `score` out 16: obstacles passed, saturating.
- `game_over` out 1: high in CRASH.

## Operation
- **Tick generation:** free-running counter 0..`TICK_DIV`-1. `tick` is a one-clock pulse at `TICK_DIV`-1. The counter runs in all states.
- **Start input:** `Key2` goes through a 2-FF synchroniser, then a falling-edge detector, producing `start_p`.
- **LFSR:** 8-bit, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, steps every clock. Lane = `lfsr[1:0]`. Obstacle x = `TRACK_LEFT` + `OBS_OFS` + lane*`LANE_W`, giving 145/245/345/445.
- **WAIT state** (reset state):
  - Outputs: `reset_game`=1, `obs_valid`=0, `obs_v_pos`=0.
  - On `start_p`: `score`←0, spawn the obstacle (`obs_v_pos`←0, x from the current lane), go to PLAY.
- **PLAY state**, on each `tick`:
  - Evaluate collision on the current obstacle and car positions. Unsigned 11-bit compares: `car_h`<`obs_h`+`OBS_W` && `obs_h`<`car_h`+`CAR_W` && `car_v`<`obs_v`+`OBS_H` && `obs_v`<`car_v`+`CAR_H`.
  - If hit: go to CRASH; obstacle frozen; score unchanged.
  - Else compute `nv` = `obs_v_pos` + speed (10-bit). If `nv` ≥ 480: respawn at y=0 in a new lane and `score`+1, saturating at 16'hFFFF. Otherwise `obs_v_pos`←`nv`.
  - Collision takes priority over respawn on the same tick.
- **CRASH state:**
  - Outputs: `game_over`=1, `obs_valid`=1; obstacle and score frozen.
  - Counts `CRASH_TICKS` ticks, then goes to WAIT. The score stays visible until the next start.
  - `start_p` is ignored in PLAY and CRASH.
- **Reset:** asynchronous reset at any point forces WAIT. Reset values: counter=0, LFSR=8'hA5, `obs_h_pos`=145, `obs_v_pos`=0, `score`=0, `obs_valid`=0, `game_over`=0, `reset_game`=1.

## Timing
- All outputs are registered or decoded directly from the state register; no combinational path from inputs.
- `Key2` falling to PLAY takes 3 clocks: 2 synchroniser stages plus 1 edge/state update. `reset_game` drops in the same cycle PLAY is entered.
- Obstacle motion and collision update only on clocks where `tick`=1; outputs are stable between ticks.
- CRASH lasts exactly `CRASH_TICKS` ticks. WAIT is entered on the clock of the final tick.

## Configuration
- `GAME_SPEEDUP_EN`:
  - Defined: speed = `OBS_SPEED` + min(`score`>>3, 7), i.e. +1 px/tick every 8 points, capped at +7.
  - Undefined: speed = `OBS_SPEED` constant; no speed logic is synthesised.

## Structure
- Package `game_pkg`:
  - state enum {WAIT, PLAY, CRASH};
  - `SCREEN_H`=480;
  - `NUM_LANES`=4;
  - LFSR seed and taps constants.
- Sub-module `lfsr8`: enable, seed reset, 8-bit state out.
- The rest is one FSM plus datapath in `game_supervisor`.

## Test plan
Bench uses `TICK_DIV`=4 and `CRASH_TICKS`=3.
- Reset, then `Key2` low: `reset_game` 1→0 and `obs_valid`=1 three clocks after the fall, with `obs_h_pos` ∈ {145,245,345,445} and `obs_v_pos`=0.
- Car at x=10'd0, y=400 (no x-overlap with any lane); 120 ticks at speed 4: `obs_v_pos` wraps from 476 to 0, `score` increments to 1 on that tick, lane re-drawn.
- Car at (145,400), obstacle forced to lane 0: on the tick where `obs_v_pos`>340, `game_over`=1 and the obstacle is frozen. 3 ticks later WAIT with `reset_game`=1 and `score` preserved.
- Overlap on the same tick as `nv`≥480: CRASH is entered, and `score` does not increment.
- `iRST_n` pulsed mid-PLAY: all outputs return to their reset values immediately. Pressing `Key2` during CRASH: no effect.
- With `GAME_SPEEDUP_EN` defined and `score` preloaded to 16: step = 6 px/tick. At `score`=200: step capped at 11.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow types and constants: FSM states, screen/lane geometry, LFSR seed and taps.
package game_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2
  } state_t;

  localparam int SCREEN_H  = 480;
  localparam int NUM_LANES = 4;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [9:0] lane_x(input logic [1:0] lane, input int base, input int pitch);
    return 10'(base + int'(lane) * pitch);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps/seed from game_pkg); advances on every enabled clock.
module lfsr8
  import game_pkg::*;
(
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       en_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/game_supervisor.sv
// Game-flow FSM: start sync, obstacle spawn/scroll, car/obstacle collision, score, crash hold.
// Optional `GAME_SPEEDUP_EN: obstacle speed rises 1 px/tick every 8 points, capped at +7.
module game_supervisor
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 833_334,
  parameter int TRACK_LEFT  = 120,
  parameter int LANE_W      = 100,
  parameter int OBS_OFS     = 25,
  parameter int OBS_W       = 50,
  parameter int OBS_H       = 60,
  parameter int CAR_W       = 50,
  parameter int CAR_H       = 80,
  parameter int OBS_SPEED   = 4,
  parameter int CRASH_TICKS = 60
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        Key2,
  input  logic [9:0]  car_h_pos,
  input  logic [8:0]  car_v_pos,
  output logic        reset_game,
  output logic [9:0]  obs_h_pos,
  output logic [8:0]  obs_v_pos,
  output logic        obs_valid,
  output logic [15:0] score,
  output logic        game_over
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CRW   = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;
  localparam logic [9:0] OBS_X0 = 10'(TRACK_LEFT + OBS_OFS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  logic             key_meta_q, key_sync_q, key_prev_q, start_p;
  logic [7:0]       lfsr;
  logic             unused_lfsr;
  logic [9:0]       spawn_x, speed, nv;
  logic [9:0]       obs_h_q, obs_h_d;
  logic [8:0]       obs_v_q, obs_v_d;
  logic [15:0]      score_q, score_d;
  logic [CRW-1:0]   crash_cnt_q, crash_cnt_d;
  logic [10:0]      ch, cv, oh, ov;
  logic             hit;

  lfsr8 u_lfsr (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .en_i     (1'b1),
    .state_o  (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:2];
  assign spawn_x     = lane_x(lfsr[1:0], TRACK_LEFT + OBS_OFS, LANE_W);
  assign tick        = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign start_p     = key_prev_q & ~key_sync_q;

`ifdef GAME_SPEEDUP_EN
  logic [2:0] bonus;
  assign bonus = (|score_q[15:6]) ? 3'd7 : score_q[5:3];
  assign speed = 10'(OBS_SPEED) + {7'd0, bonus};
`else
  assign speed = 10'(OBS_SPEED);
`endif

  assign nv = {1'b0, obs_v_q} + speed;

  // Widened to 11 bits so the far edges (x+width, y+height) cannot wrap
  assign ch  = {1'b0, car_h_pos};
  assign cv  = {2'b0, car_v_pos};
  assign oh  = {1'b0, obs_h_q};
  assign ov  = {2'b0, obs_v_q};
  assign hit = (ch < oh + 11'(OBS_W)) && (oh < ch + 11'(CAR_W)) &&
               (cv < ov + 11'(OBS_H)) && (ov < cv + 11'(CAR_H));

  always_comb begin
    state_d     = state_q;
    obs_h_d     = obs_h_q;
    obs_v_d     = obs_v_q;
    score_d     = score_q;
    crash_cnt_d = crash_cnt_q;
    case (state_q)
      WAIT: if (start_p) begin
        score_d = '0;
        obs_v_d = '0;
        obs_h_d = spawn_x;
        state_d = PLAY;
      end
      PLAY: if (tick) begin
        if (hit) begin
          state_d     = CRASH;
          crash_cnt_d = '0;
        end else if (nv >= 10'(SCREEN_H)) begin
          obs_v_d = '0;
          obs_h_d = spawn_x;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end else begin
          obs_v_d = nv[8:0];
        end
      end
      CRASH: if (tick) begin
        if (crash_cnt_q == CRW'(CRASH_TICKS - 1)) begin
          state_d = WAIT;
          obs_v_d = '0;
        end else begin
          crash_cnt_d = crash_cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= WAIT;
      cnt_q       <= '0;
      key_meta_q  <= 1'b1;
      key_sync_q  <= 1'b1;
      key_prev_q  <= 1'b1;
      obs_h_q     <= OBS_X0;
      obs_v_q     <= '0;
      score_q     <= '0;
      crash_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= tick ? '0 : cnt_q + 1'b1;
      key_meta_q  <= Key2;
      key_sync_q  <= key_meta_q;
      key_prev_q  <= key_sync_q;
      obs_h_q     <= obs_h_d;
      obs_v_q     <= obs_v_d;
      score_q     <= score_d;
      crash_cnt_q <= crash_cnt_d;
    end
  end

  assign reset_game = (state_q == WAIT);
  assign obs_valid  = (state_q != WAIT);
  assign game_over  = (state_q == CRASH);
  assign obs_h_pos  = obs_h_q;
  assign obs_v_pos  = obs_v_q;
  assign score      = score_q;

endmodule

// File: tb/tb_game_supervisor.sv
// Bench for game_supervisor: directed table + corner sequences + random play against a behavioural model.
module tb_game_supervisor;

  localparam int TD = 4;
  localparam int CT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key2 = 1'b1;
  logic [9:0]  car_h = 10'd0;
  logic [8:0]  car_v = 9'd400;
  logic        reset_game, obs_valid, game_over;
  logic [9:0]  obs_h_pos;
  logic [8:0]  obs_v_pos;
  logic [15:0] score;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  game_supervisor #(.TICK_DIV(TD), .CRASH_TICKS(CT)) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .Key2       (key2),
    .car_h_pos  (car_h),
    .car_v_pos  (car_v),
    .reset_game (reset_game),
    .obs_h_pos  (obs_h_pos),
    .obs_v_pos  (obs_v_pos),
    .obs_valid  (obs_valid),
    .score      (score),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // Behavioural model: game phase 0=waiting, 1=playing, 2=crashed
  int m_phase, m_h, m_v, m_score, m_crash_ticks, m_edge, m_lfsr;
  bit kd1, kd2, kd3;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit overlap(input int ch, input int cv, input int oh, input int ov);
    return (ch < oh + 50) && (oh < ch + 50) && (cv < ov + 60) && (ov < cv + 80);
  endfunction

  function automatic int next_lfsr(input int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return ((s << 1) | fb) & 255;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_h = 145; m_v = 0; m_score = 0; m_crash_ticks = 0;
    m_edge = 0; m_lfsr = 'hA5; kd1 = 1; kd2 = 1; kd3 = 1;
  endtask

  task automatic model_edge();
    bit tick, start;
    int lane_px, speed, nv;
    m_edge++;
    tick    = ((m_edge - 1) % TD) == TD - 1;
    lane_px = 145 + (m_lfsr % 4) * 100;
    start   = kd3 && !kd2;
`ifdef GAME_SPEEDUP_EN
    speed = 4 + ((m_score / 8 > 7) ? 7 : m_score / 8);
`else
    speed = 4;
`endif
    case (m_phase)
      0: if (start) begin
        m_score = 0; m_v = 0; m_h = lane_px; m_phase = 1;
      end
      1: if (tick) begin
        if (overlap(int'(car_h), int'(car_v), m_h, m_v)) begin
          m_phase = 2; m_crash_ticks = 0;
        end else begin
          nv = m_v + speed;
          if (nv >= 480) begin
            m_v = 0; m_h = lane_px;
            if (m_score < 65535) m_score++;
          end else m_v = nv;
        end
      end
      default: if (tick) begin
        m_crash_ticks++;
        if (m_crash_ticks == CT) begin m_phase = 0; m_v = 0; end
      end
    endcase
    kd3 = kd2; kd2 = kd1; kd1 = key2;
    m_lfsr = next_lfsr(m_lfsr);
  endtask

  task automatic compare_model();
    int e_rg, e_ov, e_go;
    e_rg = (m_phase == 0); e_ov = (m_phase != 0); e_go = (m_phase == 2);
    n_tests++;
    if (reset_game !== 1'(e_rg) || obs_valid !== 1'(e_ov) || game_over !== 1'(e_go) ||
        obs_h_pos !== 10'(m_h) || obs_v_pos !== 9'(m_v) || score !== 16'(m_score)) begin
      n_fail++;
      $display("FAIL model edge %0d: got rg=%0d ov=%0d go=%0d h=%0d v=%0d s=%0d, expected rg=%0d ov=%0d go=%0d h=%0d v=%0d s=%0d",
               m_edge, reset_game, obs_valid, game_over, obs_h_pos, obs_v_pos, score,
               e_rg, e_ov, e_go, m_h, m_v, m_score);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_model();
  endtask

  function automatic logic [31:0] sig(input int sel);
    case (sel)
      0:       return 32'(obs_v_pos);
      1:       return 32'(game_over);
      default: return 32'(reset_game);
    endcase
  endfunction

  task automatic run_until(input int sel, input int val, input int limit, input string name);
    int k = 0;
    while (sig(sel) !== 32'(val) && k < limit) begin
      cycle();
      k++;
    end
    chk(name, sig(sel), val);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rg"}, reset_game, 1);
    chk({tag, "_ov"}, obs_valid, 0);
    chk({tag, "_go"}, game_over, 0);
    chk({tag, "_h"}, obs_h_pos, 145);
    chk({tag, "_v"}, obs_v_pos, 0);
    chk({tag, "_score"}, score, 0);
  endtask

  task automatic press_start();
    key2 = 1'b0;
    run_until(2, 0, 10, "start_play");
    key2 = 1'b1;
  endtask

  typedef struct {
    bit key;
    int adv;
    bit rg;
    bit ov;
    int v;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    tbl[0] = '{1'b1, 1, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b0, 1, 1'b1, 1'b0, 0};
    tbl[2] = '{1'b0, 1, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b0, 1, 1'b0, 1'b1, 0};
    tbl[4] = '{1'b1, 4, 1'b0, 1'b1, 4};

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // Start latency and first motion step
    for (int i = 0; i < 5; i++) begin
      key2 = tbl[i].key;
      repeat (tbl[i].adv) cycle();
      chk($sformatf("tbl%0d_rg", i), reset_game, tbl[i].rg);
      chk($sformatf("tbl%0d_ov", i), obs_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_v", i), obs_v_pos, tbl[i].v);
    end
    chk("spawn_lane", (obs_h_pos >= 145 && obs_h_pos <= 445 && (obs_h_pos - 145) % 100 == 0), 1);

    // Wrap at the bottom of the screen
    run_until(0, 476, 600, "wrap_pre_v");
    chk("wrap_pre_score", score, 0);
    repeat (TD) cycle();
    chk("wrap_v", obs_v_pos, 0);
    chk("wrap_score", score, 1);
    chk("wrap_lane", (obs_h_pos >= 145 && obs_h_pos <= 445 && (obs_h_pos - 145) % 100 == 0), 1);

    // Car parked in the obstacle's lane: crash when obs_v first exceeds 340
    car_h = 10'(m_h);
    run_until(1, 1, 600, "crash_go");
    chk("crash_v", obs_v_pos, 344);
    chk("crash_score", score, 1);
    k = 0;
    while (!reset_game && k < 100) begin
      cycle();
      k++;
      if (k == 1) key2 = 1'b0;
      if (k == 5) key2 = 1'b1;
      if (k == 8) chk("crash_frozen_v", obs_v_pos, 344);
      if (k == 9) chk("crash_key_ignored", game_over, 1);
    end
    chk("crash_len", k, CT * TD);
    chk("crash_end_score", score, 1);
    chk("crash_end_v", obs_v_pos, 0);
    chk("crash_end_ov", obs_valid, 0);
    repeat (10) cycle();
    chk("wait_holds", reset_game, 1);

    // Overlap on the same tick as the wrap: collision wins, no score
    car_h = 10'd0;
    press_start();
    run_until(0, 476, 700, "race_pre_v");
    car_h = 10'(m_h);
    repeat (TD) cycle();
    chk("race_go", game_over, 1);
    chk("race_v", obs_v_pos, 476);
    chk("race_score", score, 0);

    // Asynchronous reset in the middle of play
    run_until(2, 1, 40, "race_to_wait");
    car_h = 10'd0;
    press_start();
    repeat (50) cycle();
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Random play
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 63) == 0) key2 = ~key2;
      if ($urandom_range(0, 99) == 0) begin
        car_h = 10'($urandom_range(0, 620));
        car_v = 9'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 199) == 0) car_h = 10'(m_h);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
